// File: rtl/jtdsp16_inst_cache.sv
// jtdsp16_inst_cache -- DSP16 instruction fetch loop cache.
//
// Sits between the program ROM and the instruction decoder and implements
// the "do K { N instructions }" / "redo K" loop cache. On the first pass the
// body words come from ROM and are written into a 15-entry cache. On later
// passes they are replayed from the cache while pc_halt freezes the ROM
// address unit. Interrupts are masked while a loop is active.
//
// Ports:
//   clk        system clock
//   rst_n      synchronous active-low reset
//   cen        clock enable; state advances only when high
//   rom_dout   instruction word at the current ROM address
//   do_en      decoder holds a "do" instruction this cycle
//   redo_en    decoder holds a "redo" instruction this cycle
//   loop_n     body length N for do (1..2**CW-1)
//   loop_k     iteration count K for do/redo (0 treated as 1)
//   inst       instruction word to the decoder
//   pc_halt    holds the ROM program counter during replay
//   irq_mask   high while a loop is active
//   in_loop    high while filling or replaying
//   loop_last  inst is the last word of the final iteration
//   err        (only with JTDSP16_CACHE_ERR_EN) sticky flag for ignored
//              do/redo requests; cleared only by reset
//
// Optional feature macro: JTDSP16_CACHE_ERR_EN (adds the err port).

module jtdsp16_inst_cache #(
    parameter int CW = 4,
    parameter int KW = 7
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cen,
    input  logic [15:0]   rom_dout,
    input  logic          do_en,
    input  logic          redo_en,
    input  logic [CW-1:0] loop_n,
    input  logic [KW-1:0] loop_k,
    output logic [15:0]   inst,
    output logic          pc_halt,
    output logic          irq_mask,
    output logic          in_loop,
    output logic          loop_last
`ifdef JTDSP16_CACHE_ERR_EN
    ,
    output logic          err
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        REPLAY
    } state_t;

    localparam logic [CW-1:0] N_ONE = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [KW-1:0] K_ONE = {{(KW-1){1'b0}}, 1'b1};

    state_t        state, state_nx;
    logic [CW-1:0] ptr, ptr_nx;
    logic [CW-1:0] n_len, n_nx;
    logic [KW-1:0] k_len, k_nx;
    logic [KW-1:0] rem, rem_nx;
    logic          valid, valid_nx;
    logic          cache_we;
    logic          at_end;
    logic [KW-1:0] k_eff;

    // Cache RAM is intentionally not reset.
    logic [15:0] cache [0:(2**CW)-2];

    assign at_end   = (ptr == (n_len - N_ONE));
    assign k_eff    = (loop_k == '0) ? K_ONE : loop_k;
    assign in_loop  = (state != IDLE);
    assign irq_mask = (state != IDLE);

    always_comb begin
        state_nx  = state;
        ptr_nx    = ptr;
        n_nx      = n_len;
        k_nx      = k_len;
        rem_nx    = rem;
        valid_nx  = valid;
        cache_we  = 1'b0;
        inst      = rom_dout;
        pc_halt   = 1'b0;
        loop_last = 1'b0;
        case (state)
            IDLE: begin
                // do_en wins over redo_en even when its N=0 makes it a no-op
                if (do_en) begin
                    if (loop_n != '0) begin
                        n_nx     = loop_n;
                        k_nx     = k_eff;
                        ptr_nx   = '0;
                        state_nx = FILL;
                    end
                end else if (redo_en && valid) begin
                    ptr_nx   = '0;
                    rem_nx   = k_eff;
                    state_nx = REPLAY;
                end
            end
            FILL: begin
                cache_we = 1'b1;
                ptr_nx   = ptr + N_ONE;
                if (at_end) begin
                    valid_nx = 1'b1;
                    ptr_nx   = '0;
                    if (k_len == K_ONE) begin
                        loop_last = 1'b1;
                        state_nx  = IDLE;
                    end else begin
                        rem_nx   = k_len - K_ONE;
                        state_nx = REPLAY;
                    end
                end
            end
            REPLAY: begin
                inst    = cache[ptr];
                pc_halt = 1'b1;
                ptr_nx  = ptr + N_ONE;
                if (at_end) begin
                    ptr_nx = '0;
                    if (rem == K_ONE) begin
                        loop_last = 1'b1;
                        state_nx  = IDLE;
                    end else begin
                        rem_nx = rem - K_ONE;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            ptr   <= '0;
            n_len <= '0;
            k_len <= '0;
            rem   <= '0;
            valid <= 1'b0;
        end else if (cen) begin
            state <= state_nx;
            ptr   <= ptr_nx;
            n_len <= n_nx;
            k_len <= k_nx;
            rem   <= rem_nx;
            valid <= valid_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (cen && cache_we) cache[ptr] <= rom_dout;
    end

`ifdef JTDSP16_CACHE_ERR_EN
    logic err_set;

    always_comb begin
        err_set = 1'b0;
        if (state != IDLE)  err_set = do_en | redo_en;
        else if (do_en)     err_set = (loop_n == '0);
        else if (redo_en)   err_set = !valid;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)              err <= 1'b0;
        else if (cen && err_set) err <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_jtdsp16_inst_cache.sv
// Testbench for jtdsp16_inst_cache: ROM plus program counter model, vector
// tables for the cycle-by-cycle loop sequences and hand-written sequences for
// reset, redo-after-reset and illegal nesting.

module tb_jtdsp16_inst_cache;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cen;
    logic [15:0] rom_dout;
    logic        do_en;
    logic        redo_en;
    logic [3:0]  loop_n;
    logic [6:0]  loop_k;
    logic [15:0] inst;
    logic        pc_halt;
    logic        irq_mask;
    logic        in_loop;
    logic        loop_last;
`ifdef JTDSP16_CACHE_ERR_EN
    logic        err;
`endif

    jtdsp16_inst_cache #(.CW(4), .KW(7)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cen       (cen),
        .rom_dout  (rom_dout),
        .do_en     (do_en),
        .redo_en   (redo_en),
        .loop_n    (loop_n),
        .loop_k    (loop_k),
        .inst      (inst),
        .pc_halt   (pc_halt),
        .irq_mask  (irq_mask),
        .in_loop   (in_loop),
        .loop_last (loop_last)
`ifdef JTDSP16_CACHE_ERR_EN
        ,
        .err       (err)
`endif
    );

    always #5 clk = ~clk;

    // ROM and program counter (AAU) model
    logic [15:0] rom [0:255];
    logic [7:0]  pc;
    logic        pc_ld;
    logic [7:0]  pc_ld_val;

    assign rom_dout = rom[pc];

    always @(posedge clk) begin
        if (!rst_n)                pc <= 8'd0;
        else if (pc_ld)            pc <= pc_ld_val;
        else if (cen && !pc_halt)  pc <= pc + 8'd1;
    end

    typedef struct {
        logic        cen;
        logic        do_en;
        logic        redo_en;
        logic [3:0]  n;
        logic [6:0]  k;
        logic [15:0] inst;
        logic        halt;
        logic        last;
        logic        inl;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic c, input logic d, input logic r, input logic [3:0] n,
                       input logic [6:0] k, input logic [15:0] i, input logic h,
                       input logic l, input logic il);
        vec_t v;
        v.cen = c; v.do_en = d; v.redo_en = r; v.n = n; v.k = k;
        v.inst = i; v.halt = h; v.last = l; v.inl = il;
        vecs.push_back(v);
    endtask

    task automatic run_vecs(input string tag);
        for (int i = 0; i < vecs.size(); i++) begin
            cen = vecs[i].cen; do_en = vecs[i].do_en; redo_en = vecs[i].redo_en;
            loop_n = vecs[i].n; loop_k = vecs[i].k;
            @(negedge clk);
            chk($sformatf("%s[%0d].inst", tag, i), inst, vecs[i].inst);
            chk($sformatf("%s[%0d].pc_halt", tag, i), {15'd0, pc_halt}, {15'd0, vecs[i].halt});
            chk($sformatf("%s[%0d].loop_last", tag, i), {15'd0, loop_last}, {15'd0, vecs[i].last});
            chk($sformatf("%s[%0d].in_loop", tag, i), {15'd0, in_loop}, {15'd0, vecs[i].inl});
            chk($sformatf("%s[%0d].irq_mask", tag, i), {15'd0, irq_mask}, {15'd0, vecs[i].inl});
            tick();
        end
        vecs.delete();
        cen = 1'b1; do_en = 1'b0; redo_en = 1'b0;
    endtask

    task automatic set_pc(input logic [7:0] v);
        pc_ld = 1'b1; pc_ld_val = v;
        tick();
        pc_ld = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic chk_err(input string name, input logic exp);
`ifdef JTDSP16_CACHE_ERR_EN
        @(negedge clk);
        chk(name, {15'd0, err}, {15'd0, exp});
        @(posedge clk);
        #1;
`else
        if (name.len() < 0 || exp === 1'bx) $display("%s", name);
`endif
    endtask

    initial begin
        for (int a = 0; a < 256; a++) rom[a] = 16'hE000 + 16'(a);
        rom[9]  = 16'h0D00;
        rom[10] = 16'h1000;
        rom[11] = 16'h1001;
        rom[12] = 16'h1002;
        rom[13] = 16'h2000;

        rst_n = 1'b0; cen = 1'b1; do_en = 1'b0; redo_en = 1'b0;
        loop_n = '0; loop_k = '0; pc_ld = 1'b0; pc_ld_val = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset state
        @(negedge clk);
        chk("rst.in_loop",   {15'd0, in_loop},   16'd0);
        chk("rst.pc_halt",   {15'd0, pc_halt},   16'd0);
        chk("rst.irq_mask",  {15'd0, irq_mask},  16'd0);
        chk("rst.loop_last", {15'd0, loop_last}, 16'd0);
        @(posedge clk); #1;
        chk_err("rst.err", 1'b0);

        // redo right after reset: cache empty, must be ignored
        redo_en = 1'b1; loop_k = 7'd3;
        tick();
        redo_en = 1'b0;
        @(negedge clk);
        chk("redo_cold.in_loop", {15'd0, in_loop}, 16'd0);
        chk("redo_cold.pc_halt", {15'd0, pc_halt}, 16'd0);
        @(posedge clk); #1;
        chk_err("redo_cold.err", 1'b1);
        do_reset();

        // Basic do N=3 K=2, then redo K=3
        set_pc(8'd9);
        add(1, 1, 0, 4'd3, 7'd2, 16'h0D00, 0, 0, 0);
        add(1, 0, 0, 4'd0, 7'd0, 16'h1000, 0, 0, 1);
        add(1, 0, 0, 4'd0, 7'd0, 16'h1001, 0, 0, 1);
        add(1, 0, 0, 4'd0, 7'd0, 16'h1002, 0, 0, 1);
        add(1, 0, 0, 4'd0, 7'd0, 16'h1000, 1, 0, 1);
        add(1, 0, 0, 4'd0, 7'd0, 16'h1001, 1, 0, 1);
        add(1, 0, 0, 4'd0, 7'd0, 16'h1002, 1, 1, 1);
        add(1, 0, 0, 4'd0, 7'd0, 16'h2000, 0, 0, 0);
        add(1, 0, 1, 4'd0, 7'd3, 16'hE00E, 0, 0, 0);
        for (int r = 0; r < 3; r++) begin
            add(1, 0, 0, 4'd0, 7'd0, 16'h1000, 1, 0, 1);
            add(1, 0, 0, 4'd0, 7'd0, 16'h1001, 1, 0, 1);
            add(1, 0, 0, 4'd0, 7'd0, 16'h1002, 1, (r == 2), 1);
        end
        add(1, 0, 0, 4'd0, 7'd0, 16'hE00F, 0, 0, 0);
        run_vecs("basic");

        // cen gating during REPLAY
        set_pc(8'd9);
        add(1, 1, 0, 4'd3, 7'd2, 16'h0D00, 0, 0, 0);
        add(1, 0, 0, 4'd0, 7'd0, 16'h1000, 0, 0, 1);
        add(1, 0, 0, 4'd0, 7'd0, 16'h1001, 0, 0, 1);
        add(1, 0, 0, 4'd0, 7'd0, 16'h1002, 0, 0, 1);
        add(1, 0, 0, 4'd0, 7'd0, 16'h1000, 1, 0, 1);
        add(0, 0, 0, 4'd0, 7'd0, 16'h1001, 1, 0, 1);
        add(0, 0, 0, 4'd0, 7'd0, 16'h1001, 1, 0, 1);
        add(1, 0, 0, 4'd0, 7'd0, 16'h1001, 1, 0, 1);
        add(1, 0, 0, 4'd0, 7'd0, 16'h1002, 1, 1, 1);
        add(1, 0, 0, 4'd0, 7'd0, 16'h2000, 0, 0, 0);
        run_vecs("cen");
        chk_err("cen.err", 1'b0);

        // K=1, K=0 (treated as 1, N=1), N=0 ignored
        set_pc(8'd20);
        add(1, 1, 0, 4'd2, 7'd1, 16'hE014, 0, 0, 0);
        add(1, 0, 0, 4'd0, 7'd0, 16'hE015, 0, 0, 1);
        add(1, 0, 0, 4'd0, 7'd0, 16'hE016, 0, 1, 1);
        add(1, 0, 0, 4'd0, 7'd0, 16'hE017, 0, 0, 0);
        add(1, 1, 0, 4'd1, 7'd0, 16'hE018, 0, 0, 0);
        add(1, 0, 0, 4'd0, 7'd0, 16'hE019, 0, 1, 1);
        add(1, 0, 0, 4'd0, 7'd0, 16'hE01A, 0, 0, 0);
        add(1, 1, 0, 4'd0, 7'd5, 16'hE01B, 0, 0, 0);
        add(1, 0, 0, 4'd0, 7'd0, 16'hE01C, 0, 0, 0);
        run_vecs("k1");
        chk_err("n0.err", 1'b1);

        // Reset mid-REPLAY, then redo must be ignored
        do_reset();
        set_pc(8'd9);
        do_en = 1'b1; loop_n = 4'd3; loop_k = 7'd2;
        tick();
        do_en = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        chk("midrst.pre_halt", {15'd0, pc_halt}, 16'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst.in_loop",  {15'd0, in_loop},  16'd0);
        chk("midrst.pc_halt",  {15'd0, pc_halt},  16'd0);
        chk("midrst.irq_mask", {15'd0, irq_mask}, 16'd0);
        @(posedge clk); #1;
        chk_err("midrst.err", 1'b0);
        redo_en = 1'b1; loop_k = 7'd2;
        tick();
        redo_en = 1'b0;
        @(negedge clk);
        chk("midrst.redo_in_loop", {15'd0, in_loop}, 16'd0);
        chk("midrst.redo_pc_halt", {15'd0, pc_halt}, 16'd0);
        @(posedge clk); #1;
        chk_err("midrst.redo_err", 1'b1);

        // Illegal nesting: do/redo while active are ignored, N=15 K=127
        do_reset();
        set_pc(8'd30);
        do_en = 1'b1; loop_n = 4'd15; loop_k = 7'd127;
        tick();
        begin
            int cnt = 0;
            int bad = 0;
            int last_cnt = 0;
            int last_at = -1;
            for (int c = 0; c < 3000; c++) begin
                do_en   = (c == 1);
                redo_en = (c == 100);
                loop_n  = 4'd3;
                loop_k  = 7'd2;
                @(negedge clk);
                if (!in_loop) break;
                if (inst !== 16'hE000 + 16'(31 + (c % 15))) bad++;
                if (pc_halt !== (c >= 15)) bad++;
                if (loop_last) begin
                    last_cnt++;
                    last_at = c;
                end
                cnt++;
                @(posedge clk); #1;
            end
            do_en = 1'b0; redo_en = 1'b0;
            chk("nest.length", 16'(cnt), 16'd1905);
            chk("nest.word_errors", 16'(bad), 16'd0);
            chk("nest.last_count", 16'(last_cnt), 16'd1);
            chk("nest.last_at", 16'(last_at), 16'd1904);
            chk("nest.post_inst", inst, 16'hE02E);
            @(posedge clk); #1;
        end
        chk_err("nest.err", 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
